// File: rtl/stream_demux.sv
// One-input, two-output packet demultiplexer with a one-entry register per output.
// The destination is chosen on the first beat of a packet and held until its last beat.
//   state | meaning
//   IDLE  | between packets, destination follows in_sel_i
//   LOCK0 | mid-packet, every beat goes to out0
//   LOCK1 | mid-packet, every beat goes to out1
module stream_demux #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    input  logic              in_sel_i,
    output logic              in_ready_o,
    output logic              out0_valid_o,
    output logic [DATA_W-1:0] out0_data_o,
    output logic              out0_last_o,
    input  logic              out0_ready_i,
    output logic              out1_valid_o,
    output logic [DATA_W-1:0] out1_data_o,
    output logic              out1_last_o,
    input  logic              out1_ready_i,
    output logic [7:0]        pkt_cnt0_o,
    output logic [7:0]        pkt_cnt1_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              out0_valid_q, out0_valid_d;
    logic [DATA_W-1:0] out0_data_q, out0_data_d;
    logic              out0_last_q, out0_last_d;
    logic              out1_valid_q, out1_valid_d;
    logic [DATA_W-1:0] out1_data_q, out1_data_d;
    logic              out1_last_q, out1_last_d;
    logic [7:0]        pkt_cnt0_q, pkt_cnt0_d;
    logic [7:0]        pkt_cnt1_q, pkt_cnt1_d;

    logic dest;
    logic room0, room1;
    logic accept;

    always_comb begin
        state_d      = state_q;
        out0_valid_d = out0_valid_q;
        out0_data_d  = out0_data_q;
        out0_last_d  = out0_last_q;
        out1_valid_d = out1_valid_q;
        out1_data_d  = out1_data_q;
        out1_last_d  = out1_last_q;
        pkt_cnt0_d   = pkt_cnt0_q;
        pkt_cnt1_d   = pkt_cnt1_q;

        case (state_q)
            LOCK0:   dest = 1'b0;
            LOCK1:   dest = 1'b1;
            default: dest = in_sel_i;
        endcase

        // A full register that drains this cycle can take the next beat without a bubble.
        room0      = !out0_valid_q || out0_ready_i;
        room1      = !out1_valid_q || out1_ready_i;
        in_ready_o = !reset && (dest ? room1 : room0);
        accept     = in_valid_i && in_ready_o;

        if (out0_valid_q && out0_ready_i) out0_valid_d = 1'b0;
        if (out1_valid_q && out1_ready_i) out1_valid_d = 1'b0;

        if (accept && !dest) begin
            out0_valid_d = 1'b1;
            out0_data_d  = in_data_i;
            out0_last_d  = in_last_i;
            if (in_last_i) pkt_cnt0_d = pkt_cnt0_q + 8'd1;
        end
        if (accept && dest) begin
            out1_valid_d = 1'b1;
            out1_data_d  = in_data_i;
            out1_last_d  = in_last_i;
            if (in_last_i) pkt_cnt1_d = pkt_cnt1_q + 8'd1;
        end

        if (accept) begin
            if (in_last_i)            state_d = IDLE;
            else if (state_q == IDLE) state_d = dest ? LOCK1 : LOCK0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            out0_valid_q <= 1'b0;
            out0_data_q  <= '0;
            out0_last_q  <= 1'b0;
            out1_valid_q <= 1'b0;
            out1_data_q  <= '0;
            out1_last_q  <= 1'b0;
            pkt_cnt0_q   <= 8'd0;
            pkt_cnt1_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            out0_valid_q <= out0_valid_d;
            out0_data_q  <= out0_data_d;
            out0_last_q  <= out0_last_d;
            out1_valid_q <= out1_valid_d;
            out1_data_q  <= out1_data_d;
            out1_last_q  <= out1_last_d;
            pkt_cnt0_q   <= pkt_cnt0_d;
            pkt_cnt1_q   <= pkt_cnt1_d;
        end
    end

    assign out0_valid_o = out0_valid_q;
    assign out0_data_o  = out0_data_q;
    assign out0_last_o  = out0_last_q;
    assign out1_valid_o = out1_valid_q;
    assign out1_data_o  = out1_data_q;
    assign out1_last_o  = out1_last_q;
    assign pkt_cnt0_o   = pkt_cnt0_q;
    assign pkt_cnt1_o   = pkt_cnt1_q;

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the payload width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid_i, input, 1, the input beat is valid.
REQ-005 SHALL have port in_data_i, input, DATA_W, the input payload.
REQ-006 SHALL have port in_last_i, input, 1, marks the final beat of a packet.
REQ-007 SHALL have port in_sel_i, input, 1, the destination (0 -> out0, 1 -> out1); sampled only on the first beat of a packet.
REQ-008 SHALL have port in_ready_o, output, 1, the block accepts the input beat this cycle.
REQ-009 SHALL have ports out0_valid_o / out1_valid_o, output, 1 each, the output register holds a beat.
REQ-010 SHALL have ports out0_data_o / out1_data_o, output, DATA_W each, the registered payload.
REQ-011 SHALL have ports out0_last_o / out1_last_o, output, 1 each, the registered last flag.
REQ-012 SHALL have ports out0_ready_i / out1_ready_i, input, 1 each, the downstream accepts the beat.
REQ-013 SHALL have ports pkt_cnt0_o / pkt_cnt1_o, output, 8 each, the count of completed packets routed to each output.

Function
REQ-014 Handshake: a transfer occurs on a port only in a cycle where valid and ready are both high; the payload SHALL NOT change while valid is high and ready is low.
REQ-015 Each output SHALL have a one-entry register; a beat accepted at the input SHALL appear on the selected output valid/data/last on the next cycle (latency 1).
REQ-016 The FSM SHALL have the states IDLE, LOCK0 and LOCK1; after reset it is in IDLE.
REQ-017 IDLE: the destination is in_sel_i; on an accepted beat with in_last_i=0 the FSM SHALL go to LOCK0 or LOCK1 per in_sel_i; with in_last_i=1 (single-beat packet) it SHALL stay in IDLE.
REQ-018 LOCK0/LOCK1: in_sel_i SHALL be ignored and every beat routed to the locked output; an accepted beat with in_last_i=1 SHALL return the FSM to IDLE.
REQ-019 in_ready_o SHALL be high iff the destination output register is empty, or full and being drained this cycle (outN_valid_o and outN_ready_i both high); it is combinational from the state, in_sel_i and the outN signals.
REQ-020 Simultaneous drain and fill of the same output register SHALL load the new beat with no bubble; full throughput is one beat per cycle.
REQ-021 A stalled output SHALL NOT block the other output's register from draining.
REQ-022 The non-selected output SHALL never receive a beat; at most one output register loads per cycle.
REQ-023 pkt_cntN_o SHALL increment by 1 when a beat with in_last_i=1 is accepted for output N; it wraps from 255 to 0.
REQ-024 in_valid_i low SHALL leave the state, registers and counters unchanged except for downstream drains.

Reset
REQ-025 While reset is high at a rising edge: FSM -> IDLE; out0_valid_o, out1_valid_o, out0_last_o, out1_last_o = 0; out0_data_o, out1_data_o = 0; pkt_cnt0_o, pkt_cnt1_o = 0.
REQ-026 Reset mid-packet SHALL discard the lock and any buffered beats; the first accepted beat after reset is treated as a packet start.
REQ-027 in_ready_o SHALL be 0 in any cycle where reset is high.

Verification
REQ-028 Single beat: in_sel_i=1, data 0xA5, last=1, out1_ready_i=1 -> out1_valid_o=1, data 0xA5, last=1 on the next cycle; out0_valid_o stays 0; pkt_cnt1_o=1.
REQ-029 Lock: a 3-beat packet 0x01,0x02,0x03 with in_sel_i=0,1,1 -> all three beats appear on out0 in order; the FSM returns to IDLE; pkt_cnt0_o=1, pkt_cnt1_o=0.
REQ-030 Backpressure: out0_ready_i=0 with out0 full -> in_ready_o=0 for sel 0, and the out0 payload is held stable; raising ready drains and refills in the same cycle with no bubble.
REQ-031 Independence: out1 stalled and full, a new packet to out0 -> accepted and delivered at one beat per cycle.
REQ-032 Wrap: 256 single-beat packets to out0 -> pkt_cnt0_o returns to 0.
REQ-033 Reset in LOCK1 with out1 full -> out1_valid_o=0 after the edge; the next beat routes per its own in_sel_i.
